// File: rtl/frontend_req_arbiter_if.sv
// rtl/frontend_req_arbiter_if.sv - four-core request bundle and single command/error output channel
// slave is the arbiter's view; master is the cores-plus-downstream view.
`ifndef ROW_BITS
`define ROW_BITS 14
`endif
`ifndef COL_BITS
`define COL_BITS 10
`endif
`ifndef BANK_BITS
`define BANK_BITS 3
`endif

interface frontend_req_arbiter_if #(
  parameter int ROW_BITS  = `ROW_BITS,
  parameter int COL_BITS  = `COL_BITS,
  parameter int BANK_BITS = `BANK_BITS
);
  localparam int A = ROW_BITS + COL_BITS + BANK_BITS;

  logic [3:0]           core_valid;
  logic [3:0]           core_ready;
  logic [3:0]           core_op;
  logic [7:0]           core_data_type;
  logic [4*A-1:0]       core_addr;
  logic [19:0]          core_req_id;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_op;
  logic [1:0]           out_data_type;
  logic [ROW_BITS-1:0]  out_row;
  logic [COL_BITS-1:0]  out_col;
  logic [BANK_BITS-1:0] out_bank;
  logic [4:0]           out_req_id;
  logic [1:0]           out_core_num;

  logic                 err_valid;
  logic [1:0]           err_core;

  modport slave (
    input  core_valid, core_op, core_data_type, core_addr, core_req_id, out_ready,
    output core_ready, out_valid, out_op, out_data_type, out_row, out_col, out_bank,
           out_req_id, out_core_num, err_valid, err_core
  );

  modport master (
    output core_valid, core_op, core_data_type, core_addr, core_req_id, out_ready,
    input  core_ready, out_valid, out_op, out_data_type, out_row, out_col, out_bank,
           out_req_id, out_core_num, err_valid, err_core
  );
endinterface

// File: rtl/frontend_req_arbiter.sv
// rtl/frontend_req_arbiter.sv - 4-core request arbiter with starvation aging and a one-deep command register
// Priority classes: starving > instruction > any; round-robin within the winning class.
`ifndef ROW_BITS
`define ROW_BITS 14
`endif
`ifndef COL_BITS
`define COL_BITS 10
`endif
`ifndef BANK_BITS
`define BANK_BITS 3
`endif

module frontend_req_arbiter #(
  parameter int ROW_BITS  = `ROW_BITS,
  parameter int COL_BITS  = `COL_BITS,
  parameter int BANK_BITS = `BANK_BITS,
  parameter int AGE_LIMIT = 8
) (
  input logic                  clk,
  input logic                  rst,
  frontend_req_arbiter_if.slave bus
);
  localparam int A = ROW_BITS + COL_BITS + BANK_BITS;
  localparam logic [1:0] DT_INSTRUCTION = 2'b10;
  localparam logic [1:0] DT_ILLEGAL     = 2'b11;
  localparam logic [3:0] AGE_LIM        = 4'(AGE_LIMIT);

  logic [1:0]           r_rr_ptr;
  logic [3:0]           r_wait [4];
  logic                 r_out_valid;
  logic                 r_out_op;
  logic [1:0]           r_out_data_type;
  logic [ROW_BITS-1:0]  r_out_row;
  logic [COL_BITS-1:0]  r_out_col;
  logic [BANK_BITS-1:0] r_out_bank;
  logic [4:0]           r_out_req_id;
  logic [1:0]           r_out_core_num;
  logic                 r_err_valid;
  logic [1:0]           r_err_core;

  logic                 w_slot_free;
  logic                 w_grant_en;
  logic [3:0]           w_starve;
  logic [3:0]           w_instr;
  logic [3:0]           w_class;
  logic [1:0]           w_gnt_idx;
  logic [3:0]           w_gnt_oh;
  logic                 w_gnt_op;
  logic [1:0]           w_gnt_dt;
  logic [A-1:0]         w_gnt_addr;
  logic [4:0]           w_gnt_id;
  logic                 w_load;
  logic                 w_drop;

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_grant_en  = !rst && w_slot_free && (|bus.core_valid);

  always_comb begin
    w_starve = '0;
    w_instr  = '0;
    for (int i = 0; i < 4; i++) begin
      w_starve[i] = bus.core_valid[i] && (r_wait[i] >= AGE_LIM);
      w_instr[i]  = bus.core_valid[i] && (bus.core_data_type[2*i +: 2] == DT_INSTRUCTION);
    end
    if (|w_starve)
      w_class = w_starve;
    else if (|w_instr)
      w_class = w_instr;
    else
      w_class = bus.core_valid;
  end

  always_comb begin : rr_pick
    logic [1:0] cand;
    logic       found;
    w_gnt_idx = r_rr_ptr;
    found     = 1'b0;
    cand      = r_rr_ptr;
    for (int k = 0; k < 4; k++) begin
      cand = r_rr_ptr + 2'(k);
      if (!found && w_class[cand]) begin
        w_gnt_idx = cand;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    w_gnt_oh   = w_grant_en ? (4'b0001 << w_gnt_idx) : 4'b0000;
    w_gnt_op   = bus.core_op[w_gnt_idx];
    w_gnt_dt   = bus.core_data_type[2*int'(w_gnt_idx) +: 2];
    w_gnt_addr = bus.core_addr[A*int'(w_gnt_idx) +: A];
    w_gnt_id   = bus.core_req_id[5*int'(w_gnt_idx) +: 5];
    w_load     = w_grant_en && (w_gnt_dt != DT_ILLEGAL);
    w_drop     = w_grant_en && (w_gnt_dt == DT_ILLEGAL);
  end

  // Aging: a core only accumulates wait while it is asking and losing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        r_wait[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.core_valid[i] || w_gnt_oh[i])
          r_wait[i] <= 4'd0;
        else if (r_wait[i] != 4'hF)
          r_wait[i] <= r_wait[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr        <= 2'd0;
      r_out_valid     <= 1'b0;
      r_out_op        <= 1'b0;
      r_out_data_type <= 2'd0;
      r_out_row       <= '0;
      r_out_col       <= '0;
      r_out_bank      <= '0;
      r_out_req_id    <= 5'd0;
      r_out_core_num  <= 2'd0;
      r_err_valid     <= 1'b0;
      r_err_core      <= 2'd0;
    end else begin
      if (w_grant_en)
        r_rr_ptr <= w_gnt_idx + 2'd1;
      // An illegal grant never loads, so a dequeue in the same cycle still empties the slot.
      if (w_load) begin
        r_out_valid     <= 1'b1;
        r_out_op        <= w_gnt_op;
        r_out_data_type <= w_gnt_dt;
        r_out_row       <= w_gnt_addr[A-1 -: ROW_BITS];
        r_out_col       <= w_gnt_addr[COL_BITS+BANK_BITS-1 -: COL_BITS];
        r_out_bank      <= w_gnt_addr[BANK_BITS-1:0];
        r_out_req_id    <= w_gnt_id;
        r_out_core_num  <= w_gnt_idx;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_err_valid <= w_drop;
      if (w_drop)
        r_err_core <= w_gnt_idx;
    end
  end

  assign bus.core_ready    = w_gnt_oh;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_op        = r_out_op;
  assign bus.out_data_type = r_out_data_type;
  assign bus.out_row       = r_out_row;
  assign bus.out_col       = r_out_col;
  assign bus.out_bank      = r_out_bank;
  assign bus.out_req_id    = r_out_req_id;
  assign bus.out_core_num  = r_out_core_num;
  assign bus.err_valid     = r_err_valid;
  assign bus.err_core      = r_err_core;

endmodule

// File: tb/tb_frontend_req_arbiter.sv
// tb/tb_frontend_req_arbiter.sv - directed bench for frontend_req_arbiter
// Inputs change 1ns after the rising edge; combinational outputs checked 1ns later, registers 1ns after the next edge.
module tb_frontend_req_arbiter;
  localparam int RB = 14;
  localparam int CB = 10;
  localparam int BB = 3;
  localparam int A  = RB + CB + BB;
  localparam logic [1:0] DT_W = 2'b00;
  localparam logic [1:0] DT_A = 2'b01;
  localparam logic [1:0] DT_I = 2'b10;
  localparam logic [1:0] DT_X = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frontend_req_arbiter_if #(.ROW_BITS(RB), .COL_BITS(CB), .BANK_BITS(BB)) bus ();

  frontend_req_arbiter #(
    .ROW_BITS(RB), .COL_BITS(CB), .BANK_BITS(BB), .AGE_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_core(input int i, input logic v, input logic op, input logic [1:0] dt,
                          input logic [A-1:0] addr, input logic [4:0] id);
    bus.core_valid[i]            = v;
    bus.core_op[i]               = op;
    bus.core_data_type[2*i +: 2] = dt;
    bus.core_addr[A*i +: A]      = addr;
    bus.core_req_id[5*i +: 5]    = id;
  endtask

  task automatic clear_cores();
    for (int i = 0; i < 4; i++)
      set_core(i, 1'b0, 1'b0, DT_W, '0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_cores();
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state, with every core requesting
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      set_core(i, 1'b1, 1'b0, DT_W, A'(i), 5'(i));
    #12;
    chk("rst_core_ready", bus.core_ready, 4'b0000);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_err_valid", bus.err_valid, 1'b0);
    chk("rst_out_row", bus.out_row, 0);
    chk("rst_err_core", bus.err_core, 0);

    // all four WEIGHTS: 0,1,2,3,0 with continuous out_valid
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      set_core(i, 1'b1, 1'b0, DT_W, A'(i), 5'(10 + i));
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("rr_core_ready", bus.core_ready, 4'b0001 << (k % 4));
      tick();
      chk("rr_out_valid", bus.out_valid, 1'b1);
      chk("rr_core_num", bus.out_core_num, k % 4);
      chk("rr_req_id", bus.out_req_id, 10 + (k % 4));
    end
    clear_cores();
    settle();
    chk("idle_core_ready", bus.core_ready, 4'b0000);
    tick();
    chk("dequeue_clears", bus.out_valid, 1'b0);

    // instruction class beats weights, then round-robin resumes
    do_reset();
    bus.out_ready = 1'b1;
    set_core(0, 1'b1, 1'b0, DT_W, A'(0), 5'd1);
    set_core(1, 1'b1, 1'b0, DT_W, A'(0), 5'd2);
    set_core(2, 1'b1, 1'b1, DT_I, A'(0), 5'd3);
    settle();
    chk("instr_first", bus.core_ready, 4'b0100);
    tick();
    chk("instr_core_num", bus.out_core_num, 2);
    chk("instr_dt", bus.out_data_type, DT_I);
    set_core(2, 1'b0, 1'b0, DT_W, '0, 5'd0);
    settle();
    chk("instr_then0", bus.core_ready, 4'b0001);
    tick();
    chk("instr_then0_num", bus.out_core_num, 0);
    set_core(0, 1'b0, 1'b0, DT_W, '0, 5'd0);
    settle();
    chk("instr_then1", bus.core_ready, 4'b0010);
    tick();
    chk("instr_then1_num", bus.out_core_num, 1);
    chk("instr_then1_id", bus.out_req_id, 2);
    set_core(1, 1'b0, 1'b0, DT_W, '0, 5'd0);

    // address decode from core 1
    set_core(1, 1'b1, 1'b1, DT_A, {14'd5, 10'd9, 3'd3}, 5'd17);
    settle();
    chk("dec_ready", bus.core_ready, 4'b0010);
    tick();
    chk("dec_row", bus.out_row, 5);
    chk("dec_col", bus.out_col, 9);
    chk("dec_bank", bus.out_bank, 3);
    chk("dec_core_num", bus.out_core_num, 1);
    chk("dec_req_id", bus.out_req_id, 17);
    chk("dec_op", bus.out_op, 1'b1);
    chk("dec_dt", bus.out_data_type, DT_A);
    clear_cores();

    // backpressure for 10 cycles, both cores 0 and 3 age into starvation
    do_reset();
    set_core(0, 1'b1, 1'b0, DT_W, A'(0), 5'd1);
    settle();
    chk("bp_first_grant", bus.core_ready, 4'b0001);
    tick();
    chk("bp_loaded", bus.out_valid, 1'b1);
    set_core(0, 1'b1, 1'b0, DT_W, A'(0), 5'd2);
    set_core(3, 1'b1, 1'b0, DT_W, A'(0), 5'd3);
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("bp_no_ready", bus.core_ready, 4'b0000);
      tick();
      chk("bp_hold_valid", bus.out_valid, 1'b1);
      chk("bp_hold_id", bus.out_req_id, 1);
    end
    bus.out_ready = 1'b1;
    settle();
    chk("starve_rr_3", bus.core_ready, 4'b1000);
    tick();
    chk("starve_num3", bus.out_core_num, 3);
    chk("starve_id3", bus.out_req_id, 3);
    set_core(3, 1'b1, 1'b0, DT_W, A'(0), 5'd5);
    settle();
    chk("starve_0", bus.core_ready, 4'b0001);
    tick();
    chk("starve_num0", bus.out_core_num, 0);
    chk("starve_id0", bus.out_req_id, 2);
    // core 3's counter restarted at its grant, so fresh core 1 wins by round-robin
    set_core(0, 1'b0, 1'b0, DT_W, '0, 5'd0);
    set_core(1, 1'b1, 1'b0, DT_W, A'(0), 5'd6);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bp2_no_ready", bus.core_ready, 4'b0000);
      tick();
    end
    bus.out_ready = 1'b1;
    settle();
    chk("age_cleared", bus.core_ready, 4'b0010);
    tick();
    chk("age_cleared_num", bus.out_core_num, 1);
    clear_cores();

    // illegal data type: consumed, error pulse, never loaded
    set_core(2, 1'b1, 1'b0, DT_X, A'(0), 5'd7);
    settle();
    chk("ill2_ready", bus.core_ready, 4'b0100);
    tick();
    chk("ill2_err_valid", bus.err_valid, 1'b1);
    chk("ill2_err_core", bus.err_core, 2);
    chk("ill2_out_valid", bus.out_valid, 1'b0);
    set_core(2, 1'b0, 1'b0, DT_W, '0, 5'd0);
    set_core(0, 1'b1, 1'b0, DT_X, A'(0), 5'd8);
    settle();
    chk("ill0_ready", bus.core_ready, 4'b0001);
    tick();
    chk("ill0_err_valid", bus.err_valid, 1'b1);
    chk("ill0_err_core", bus.err_core, 0);
    chk("ill0_out_valid", bus.out_valid, 1'b0);
    clear_cores();
    tick();
    chk("err_pulse_ends", bus.err_valid, 1'b0);
    chk("err_out_valid", bus.out_valid, 1'b0);

    // reset mid-transfer discards the command and rewinds rr_ptr
    bus.out_ready = 1'b0;
    set_core(1, 1'b1, 1'b0, DT_W, A'(0), 5'd9);
    settle();
    chk("mid_ready", bus.core_ready, 4'b0010);
    tick();
    chk("mid_loaded", bus.out_valid, 1'b1);
    for (int i = 0; i < 4; i++)
      set_core(i, 1'b1, 1'b0, DT_W, A'(0), 5'(20 + i));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_ready", bus.core_ready, 4'b0000);
    chk("mid_rst_id", bus.out_req_id, 0);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_grant0", bus.core_ready, 4'b0001);
    tick();
    chk("post_rst_num", bus.out_core_num, 0);
    chk("post_rst_valid", bus.out_valid, 1'b1);
    chk("post_rst_id", bus.out_req_id, 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/frontend_req_arbiter.md
FRONTEND_REQ_ARBITER -- requirements
Module: frontend_req_arbiter

Interface
REQ-001 SHALL expose parameter ROW_BITS, default `ROW_BITS, row address width.
REQ-002 SHALL expose parameter COL_BITS, default `COL_BITS, column address width.
REQ-003 SHALL expose parameter BANK_BITS, default `BANK_BITS, bank address width; A = ROW_BITS+COL_BITS+BANK_BITS.
REQ-004 SHALL expose parameter AGE_LIMIT, default 8, wait cycles before a core is starving (range 1..15).
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 core_valid  input  4  request valid per core (bit i = core i).
REQ-008 core_ready  output  4  request accepted per core.
REQ-009 core_op  input  4  per-core op, 1 = OP_READ, 0 = OP_WRITE.
REQ-010 core_data_type  input  8  per-core 2-bit request_data_type_t, core i at [2i+1:2i].
REQ-011 core_addr  input  4*A  per-core address, core i at [A*i+A-1:A*i].
REQ-012 core_req_id  input  20  per-core 5-bit req_id_t.
REQ-013 out_valid  output  1  registered command valid.
REQ-014 out_ready  input  1  downstream accepts command.
REQ-015 out_op, out_data_type, out_row, out_col, out_bank  output  1/2/ROW_BITS/COL_BITS/BANK_BITS  decoded command.
REQ-016 out_req_id, out_core_num  output  5/2  tag of the held command.
REQ-017 err_valid, err_core  output  1/2  one-cycle pulse: illegal data_type dropped, and its core.

Function
REQ-018 Output slot SHALL be free in a cycle iff out_valid==0 or out_ready==1.
REQ-019 When slot is free and any core_valid is high, exactly one core SHALL be granted; otherwise no grant.
REQ-020 core_ready SHALL be combinational, one-hot or zero, asserted only for the granted core; never asserted for a core with core_valid low.
REQ-021 Grant priority, highest first: (a) starving cores, (b) cores presenting DATA_TYPE_INSTRUCTION, (c) all remaining valid cores; within a class, round-robin from pointer rr_ptr upward, wrapping 3->0.
REQ-022 After a grant to core g, rr_ptr SHALL become (g+1) mod 4; unchanged when no grant.
REQ-023 Per-core 4-bit wait counter: increments each cycle core_valid high and not granted, saturates at 15; clears on grant or core_valid low.
REQ-024 Core is starving when its wait counter >= AGE_LIMIT.
REQ-025 Granted request with data_type 00/01/10 SHALL load output register next edge: out_valid=1, fields copied; latency grant-to-out_valid = 1 cycle.
REQ-026 Address decode: row = addr[A-1:COL_BITS+BANK_BITS], col = addr[COL_BITS+BANK_BITS-1:BANK_BITS], bank = addr[BANK_BITS-1:0].
REQ-027 Granted request with data_type 2'b11 SHALL be consumed (core_ready high), not loaded; next cycle err_valid=1, err_core=g; out_valid SHALL be 0 that cycle if out_ready had dequeued the previous command, else unchanged.
REQ-028 Simultaneous dequeue and grant SHALL replace the command with no bubble (back-to-back throughput 1/cycle).
REQ-029 out_valid high with out_ready low: all out_* fields SHALL hold stable, core_ready SHALL be 0.
REQ-030 Dequeue without grant SHALL clear out_valid next edge.

Reset
REQ-031 While rst high: out_valid=0, err_valid=0, all out_* fields and err_core=0, rr_ptr=0, wait counters=0; core_ready=0.
REQ-032 Reset asserted mid-transfer SHALL discard the held command; no partial state survives deassertion.

Verification
REQ-033 All 4 cores valid, type WEIGHTS, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, out_valid continuous.
REQ-034 rr_ptr=0, core 2 INSTRUCTION, cores 0,1 WEIGHTS -> core 2 granted first, then 0, then 1.
REQ-035 out_ready=0 for 10 cycles, cores 0,3 valid, AGE_LIMIT=8 -> on release core 3 (wait 10, rr from ptr) or starving order respected; counters clear on grant.
REQ-036 Core 1 addr with row=5, col=9, bank=3 packed {row,col,bank} -> out_row=5, out_col=9, out_bank=3, out_core_num=1, req_id echoed.
REQ-037 Core 0 data_type 2'b11 -> core_ready[0]=1, next cycle err_valid=1, err_core=0, out_valid unaffected.
REQ-038 rst pulsed while out_valid=1, out_ready=0 -> out_valid=0 immediately, rr_ptr=0, next grant follows from core 0.
